coincidence_pulse_generator: RTL and testbench

- Transmit-side counterpart to the coincidence detection path. Emits programmable pulse pairs on two channel outputs (A and B) with a set lead/lag offset.
- Drives the A/B inputs of the coincidence system for self-test and muon-decay emulation, in place of the debounced buttons.
- Sequenced by an FSM with per-channel width counters, a shared offset/gap timer and a pair counter.

---
 rtl/coincidence_pulse_generator.sv | 165 ++++++++++++++++
 tb/tb_coincidence_pulse_generator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/coincidence_pulse_generator.sv
// Pulse-pair generator: emits a leading and a trailing pulse on A/B with a programmable
// offset, repeated after a fixed gap for count_req pairs (or until stop when count_req=0).
module coincidence_pulse_generator #(
    parameter int PULSE_CYCLES = 1000,
    parameter int GAP_CYCLES   = 500_000_000,
    parameter int OFFSET_W     = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [OFFSET_W-1:0] offset_cycles,
    input  logic                b_first,
    input  logic [15:0]         count_req,
    output logic                out_A,
    output logic                out_B,
    output logic                busy,
    output logic                pair_done,
    output logic [15:0]         pairs_sent,
    output logic [1:0]          dbg_state
);

    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int OW = OFFSET_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAIR = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e                state_q;
    logic                  lead_q;
    logic                  trail_q;
    logic [PW-1:0]         lead_rem_q;
    logic [PW-1:0]         trail_rem_q;
    logic [OW-1:0]         off_q;
    logic [GW-1:0]         gap_q;
    logic [OFFSET_W-1:0]   off_cfg_q;
    logic                  bf_q;
    logic [15:0]           count_q;
    logic [15:0]           pairs_q;
    logic                  busy_q;
    logic                  pair_done_q;

    logic                  lead_ends;
    logic                  trail_ends;
    logic                  burst_done;
    logic                  launch;
    logic [OFFSET_W-1:0]   pair_off;

    // A channel's pulse is over after this edge if it is already low or on its last cycle.
    assign lead_ends  = !lead_q || (lead_rem_q == PW'(1));
    assign trail_ends = (off_q == '0) && (!trail_q || (trail_rem_q == PW'(1)));
    assign burst_done = (count_q != 16'd0) && (pairs_q == count_q);
    assign launch     = ((state_q == IDLE) && start) ||
                        ((state_q == GAP) && !stop && (gap_q == '0) && !burst_done);
    assign pair_off   = (state_q == IDLE) ? offset_cycles : off_cfg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lead_q      <= 1'b0;
            trail_q     <= 1'b0;
            lead_rem_q  <= '0;
            trail_rem_q <= '0;
            off_q       <= '0;
            gap_q       <= '0;
            off_cfg_q   <= '0;
            bf_q        <= 1'b0;
            count_q     <= '0;
            pairs_q     <= '0;
            busy_q      <= 1'b0;
            pair_done_q <= 1'b0;
        end else begin
            pair_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        off_cfg_q <= offset_cycles;
                        bf_q      <= b_first;
                        count_q   <= count_req;
                        pairs_q   <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= PAIR;
                    end
                end
                PAIR: begin
                    if (stop) begin
                        lead_q  <= 1'b0;
                        trail_q <= 1'b0;
                        off_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (lead_ends && trail_ends) begin
                        lead_q      <= 1'b0;
                        trail_q     <= 1'b0;
                        pair_done_q <= 1'b1;
                        pairs_q     <= (pairs_q == 16'hFFFF) ? pairs_q : pairs_q + 16'd1;
                        gap_q       <= GW'(GAP_CYCLES - 1);
                        state_q     <= GAP;
                    end else begin
                        if (lead_q) begin
                            if (lead_rem_q == PW'(1)) lead_q <= 1'b0;
                            else                      lead_rem_q <= lead_rem_q - PW'(1);
                        end
                        if (off_q > OW'(1)) begin
                            off_q <= off_q - OW'(1);
                        end else if (off_q == OW'(1)) begin
                            off_q       <= '0;
                            trail_q     <= 1'b1;
                            trail_rem_q <= PW'(PULSE_CYCLES);
                        end else if (trail_q) begin
                            if (trail_rem_q == PW'(1)) trail_q <= 1'b0;
                            else                       trail_rem_q <= trail_rem_q - PW'(1);
                        end
                    end
                end
                GAP: begin
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (gap_q == '0) begin
                        if (burst_done) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= PAIR;
                        end
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase

            // Start of every pair: leading pulse rises now, trailing one now or after the offset.
            if (launch) begin
                lead_q     <= 1'b1;
                lead_rem_q <= PW'(PULSE_CYCLES);
                if (pair_off == '0) begin
                    trail_q     <= 1'b1;
                    trail_rem_q <= PW'(PULSE_CYCLES);
                    off_q       <= '0;
                end else begin
                    trail_q <= 1'b0;
                    off_q   <= {1'b0, pair_off};
                end
            end
        end
    end

    // bf_q only changes in IDLE, where both pulse flops are low, so the swap never glitches.
    assign out_A      = bf_q ? trail_q : lead_q;
    assign out_B      = bf_q ? lead_q  : trail_q;
    assign busy       = busy_q;
    assign pair_done  = pair_done_q;
    assign pairs_sent = pairs_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_coincidence_pulse_generator.sv
// Bench for coincidence_pulse_generator: per-cycle expected outputs are derived from the
// pair/gap timing formulas, queued at start and popped as each DUT cycle is sampled.
module tb_coincidence_pulse_generator;

    localparam int P  = 4;
    localparam int G  = 10;
    localparam int OW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic [OW-1:0] offset_cycles;
    logic          b_first;
    logic [15:0]   count_req;
    logic          out_A;
    logic          out_B;
    logic          busy;
    logic          pair_done;
    logic [15:0]   pairs_sent;
    logic [1:0]    dbg_state;

    logic [19:0] exp_q[$];
    int tests_run;
    int tests_failed;

    coincidence_pulse_generator #(
        .PULSE_CYCLES(P),
        .GAP_CYCLES  (G),
        .OFFSET_W    (OW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .offset_cycles(offset_cycles),
        .b_first      (b_first),
        .count_req    (count_req),
        .out_A        (out_A),
        .out_B        (out_B),
        .busy         (busy),
        .pair_done    (pair_done),
        .pairs_sent   (pairs_sent),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] observed();
        return {out_A, out_B, busy, pair_done, pairs_sent};
    endfunction

    // Expected {A, B, busy, pair_done, pairs_sent} in cycle i of an uninterrupted burst.
    function automatic logic [19:0] model_run(int i, int off, bit bf, int cnt);
        int period;
        int rel;
        int p;
        int w;
        int ps;
        logic lead;
        logic trail;
        logic done;
        period = off + P + G;
        if (cnt != 0 && i >= 1 + cnt * period) return {4'b0000, 16'(cnt)};
        rel   = i - 1;
        p     = rel / period;
        w     = rel % period;
        lead  = (w < P);
        trail = (w >= off) && (w < off + P);
        done  = (w == off + P);
        ps    = p + ((w >= off + P) ? 1 : 0);
        if (ps > 65535) ps = 65535;
        return {bf ? trail : lead, bf ? lead : trail, 1'b1, done, 16'(ps)};
    endfunction

    function automatic logic [19:0] model(int i, int off, bit bf, int cnt, int abort_c, bit abort_rst);
        logic [19:0] at_abort;
        if (abort_c > 0 && i > abort_c) begin
            at_abort = model_run(abort_c, off, bf, cnt);
            return {4'b0000, abort_rst ? 16'd0 : at_abort[15:0]};
        end
        return model_run(i, off, bf, cnt);
    endfunction

    task automatic idle_cycles(int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // Start a burst and check n cycles; abort_c>0 asserts stop (or reset) during that cycle.
    task automatic run_burst(string name, int off, bit bf, int cnt, int n,
                             int abort_c, bit abort_rst, bit disturb);
        logic [19:0] exp;
        logic [19:0] got;
        @(negedge clk);
        offset_cycles = OW'(off);
        b_first       = bf;
        count_req     = 16'(cnt);
        start         = 1'b1;
        stop          = 1'b0;
        for (int i = 1; i <= n; i++) exp_q.push_back(model(i, off, bf, cnt, abort_c, abort_rst));
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            got = observed();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL %s cycle %0d: got A=%b B=%b busy=%b done=%b sent=%0d, expected A=%b B=%b busy=%b done=%b sent=%0d",
                         name, i, got[19], got[18], got[17], got[16], got[15:0],
                         exp[19], exp[18], exp[17], exp[16], exp[15:0]);
            end
            start = 1'b0;
            stop  = 1'b0;
            if (!abort_rst) rst_n = 1'b1;
            if (disturb && i == 2) begin
                start         = 1'b1;
                offset_cycles = OW'(9);
                b_first       = ~bf;
                count_req     = 16'd5;
            end
            if (i == abort_c) begin
                if (abort_rst) begin
                    rst_n = 1'b0;
                    #1;
                    tests_run++;
                    if (observed() !== 20'd0 || dbg_state !== 2'd0) begin
                        tests_failed++;
                        $display("FAIL %s async_drop: got %h state=%0d, expected 0 state=0",
                                 name, observed(), dbg_state);
                    end
                end else begin
                    stop = 1'b1;
                end
            end else if (abort_rst && i == abort_c + 1) begin
                rst_n = 1'b1;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        start         = 1'b1;
        stop          = 1'b0;
        offset_cycles = '0;
        b_first       = 1'b0;
        count_req     = 16'd1;
        idle_cycles(3);
        tests_run++;
        if (observed() !== 20'd0 || dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %h state=%0d, expected 0 state=0", observed(), dbg_state);
        end
        start = 1'b0;
        rst_n = 1'b1;
        idle_cycles(3);
        tests_run++;
        if (observed() !== 20'd0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %h, expected 0", observed());
        end
    endtask

    task automatic test_single_pair();
        run_burst("s1_single", 2, 1'b0, 1, 20, 0, 1'b0, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        run_burst("s2_three_pairs", 0, 1'b1, 3, 46, 0, 1'b0, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_disjoint();
        run_burst("s3_disjoint", 6, 1'b1, 1, 24, 0, 1'b0, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_stop_restart();
        run_burst("s4_stop", 2, 1'b0, 0, 29, 20, 1'b0, 1'b0);
        run_burst("s4_restart", 2, 1'b0, 1, 20, 0, 1'b0, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_ignore_inputs();
        run_burst("s5_ignore", 2, 1'b0, 1, 20, 0, 1'b0, 1'b1);
        idle_cycles(2);
    endtask

    task automatic test_reset_midpulse();
        run_burst("s6_reset", 2, 1'b0, 2, 12, 3, 1'b1, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_max_offset();
        run_burst("s6_max_offset", (1 << OW) - 1, 1'b0, 1, (1 << OW) + P + G + 4, 0, 1'b0, 1'b0);
        idle_cycles(2);
    endtask

    task automatic test_random();
        int off;
        int cnt;
        bit bf;
        for (int r = 0; r < 3; r++) begin
            off = $urandom_range(0, 12);
            cnt = $urandom_range(1, 2);
            bf  = 1'($urandom_range(0, 1));
            run_burst("rand_burst", off, bf, cnt, cnt * (off + P + G) + 3, 0, 1'b0, 1'b0);
            idle_cycles(1);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single_pair();
        test_back_to_back();
        test_disjoint();
        test_stop_restart();
        test_ignore_inputs();
        test_reset_midpulse();
        test_max_offset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
